// File: rtl/maze_job_arbiter_if.sv
// maze_job_arbiter_if: requester, solver, move and result signals of the maze job arbiter
interface maze_job_arbiter_if;
  logic [1:0]  req_valid;
  logic [3:0]  req_cell;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        slv_in_valid;
  logic [1:0]  slv_in;
  logic        slv_out_valid;
  logic [1:0]  slv_out;
  logic        mv_valid;
  logic [1:0]  mv_dir;
  logic        mv_id;
  logic        res_valid;
  logic        res_id;
  logic [12:0] res_moves;
  logic [1:0]  res_err;
  modport slave (
    input  req_valid, req_cell, slv_out_valid, slv_out,
    output req_ready, grant, slv_in_valid, slv_in, mv_valid, mv_dir, mv_id,
           res_valid, res_id, res_moves, res_err
  );
  modport master (
    output req_valid, req_cell, slv_out_valid, slv_out,
    input  req_ready, grant, slv_in_valid, slv_in, mv_valid, mv_dir, mv_id,
           res_valid, res_id, res_moves, res_err
  );
endinterface

// File: rtl/maze_job_arbiter.sv
// maze_job_arbiter: round-robin sharing of one maze solver between two frame requesters
module maze_job_arbiter #(
  parameter int CELLS     = 289,
  parameter int MAX_WAIT  = 16,
  parameter int MAX_MOVES = 8191,
  parameter int COOL_CYC  = 2
) (
  input logic               clk,
  input logic               rst_n,
  maze_job_arbiter_if.slave bus
);
  localparam int AW = $clog2(CELLS + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int CW = $clog2(COOL_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, RUN, DONE, COOL} state_t;
  state_t state, state_n;
  logic [1:0] mem [CELLS];
  logic [AW-1:0] w, r;
  logic [WW-1:0] wc;
  logic [12:0] mc;
  logic [CW-1:0] cc;
  logic gid, ptr, ovf;
  logic start, pick, acc, last_w, load_end, feed_end, feeding, wait_to, cool_end, fwd;
  assign start    = state == IDLE && |bus.req_valid;
  assign pick     = &bus.req_valid ? ~ptr : bus.req_valid[1];
  assign acc      = state == LOAD && bus.req_valid[gid];
  assign last_w   = w == AW'(CELLS - 1);
  assign load_end = acc && last_w;
  assign feed_end = r == AW'(CELLS);
  assign feeding  = state == FEED && !feed_end;
  assign wait_to  = wc == WW'(MAX_WAIT - 1);
  assign cool_end = cc == CW'(COOL_CYC - 1);
  assign fwd      = bus.slv_out_valid && (state == WAIT || (state == RUN && mc != 13'(MAX_MOVES)));
  assign bus.req_ready = state == LOAD ? {gid, ~gid} : 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = load_end ? FEED : LOAD;
      FEED:    state_n = feed_end ? WAIT : FEED;
      WAIT:    state_n = bus.slv_out_valid ? RUN : wait_to ? DONE : WAIT;
      RUN:     state_n = bus.slv_out_valid ? RUN : DONE;
      DONE:    state_n = COOL;
      COOL:    state_n = cool_end ? IDLE : COOL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (acc) mem[w] <= gid ? bus.req_cell[3:2] : bus.req_cell[1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gid <= 1'b0;
      ptr <= 1'b1;
      w <= '0;
      r <= '0;
      wc <= '0;
      mc <= '0;
      cc <= '0;
      ovf <= 1'b0;
      bus.grant <= 2'b00;
      bus.slv_in_valid <= 1'b0;
      bus.slv_in <= 2'b00;
      bus.mv_valid <= 1'b0;
      bus.mv_dir <= 2'b00;
      bus.mv_id <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_id <= 1'b0;
      bus.res_moves <= '0;
      bus.res_err <= 2'b00;
    end else begin
      if (start) begin
        gid <= pick;
        ptr <= pick;
        bus.grant <= pick ? 2'b10 : 2'b01;
        w <= '0;
      end else if (state == DONE) bus.grant <= 2'b00;
      if (acc) w <= w + 1'b1;
      bus.slv_in_valid <= load_end || feeding;
      bus.slv_in <= load_end ? mem[0] : feeding ? mem[r] : 2'b00;
      r <= load_end ? AW'(1) : r + 1'b1;
      wc <= state == WAIT ? wc + 1'b1 : '0;
      mc <= state == FEED ? '0 : mc + 13'(fwd);
      ovf <= state == FEED ? 1'b0 : ovf | (state == RUN && bus.slv_out_valid && !fwd);
      bus.mv_valid <= fwd;
      bus.mv_dir <= fwd ? bus.slv_out : 2'b00;
      bus.mv_id <= fwd & gid;
      bus.res_valid <= state_n == DONE;
      if (state_n == DONE) begin
        bus.res_id <= gid;
        bus.res_moves <= mc;
        bus.res_err <= state == WAIT ? 2'd1 : {ovf, 1'b0};
      end
      cc <= state == COOL ? cc + 1'b1 : '0;
    end
endmodule

// File: tb/tb_maze_job_arbiter.sv
// tb_maze_job_arbiter: table-driven jobs with scoreboard queues against two arbiter instances
module tb_maze_job_arbiter;
  localparam int CELLS = 289;
  localparam int MAX_WAIT = 16;
  localparam int MB = 20;
  typedef struct {
    logic [1:0] mask;
    int gap;
    int moves;
    bit silent;
    bit spur;
    bit id;
    int a_moves;
    int a_err;
    int b_moves;
    int b_err;
  } job_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int run = 0;
  logic [1:0] cellq [$];
  logic [2:0] mvq_a [$];
  logic [2:0] mvq_b [$];
  logic [15:0] resq_a [$];
  logic [15:0] resq_b [$];
  job_t jobs [7];
  maze_job_arbiter_if bus_a ();
  maze_job_arbiter_if bus_b ();
  maze_job_arbiter dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  maze_job_arbiter #(.MAX_MOVES(MB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  assign bus_b.req_valid = bus_a.req_valid;
  assign bus_b.req_cell = bus_a.req_cell;
  assign bus_b.slv_out_valid = bus_a.slv_out_valid;
  assign bus_b.slv_out = bus_a.slv_out;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  function automatic logic [27:0] outs_a();
    return {bus_a.req_ready, bus_a.grant, bus_a.slv_in_valid, bus_a.slv_in, bus_a.mv_valid,
            bus_a.mv_dir, bus_a.mv_id, bus_a.res_valid, bus_a.res_id, bus_a.res_moves, bus_a.res_err};
  endfunction
  function automatic logic [27:0] outs_b();
    return {bus_b.req_ready, bus_b.grant, bus_b.slv_in_valid, bus_b.slv_in, bus_b.mv_valid,
            bus_b.mv_dir, bus_b.mv_id, bus_b.res_valid, bus_b.res_id, bus_b.res_moves, bus_b.res_err};
  endfunction
  always @(negedge clk)
    if (!rst_n) run = 0;
    else begin
      if (bus_a.slv_in_valid) begin
        run++;
        if (cellq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slv_in_unexpected got %0d want none", bus_a.slv_in);
        end else chk("slv_in", bus_a.slv_in, cellq.pop_front());
      end else begin
        chk("slv_in_idle_zero", bus_a.slv_in, 0);
        if (run > 0) chk("feed_len", run, CELLS);
        run = 0;
      end
      if (bus_a.mv_valid) begin
        if (mvq_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mv_a_unexpected got %0d want none", {bus_a.mv_id, bus_a.mv_dir});
        end else chk("mv_a", {bus_a.mv_id, bus_a.mv_dir}, mvq_a.pop_front());
      end
      if (bus_b.mv_valid) begin
        if (mvq_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mv_b_unexpected got %0d want none", {bus_b.mv_id, bus_b.mv_dir});
        end else chk("mv_b", {bus_b.mv_id, bus_b.mv_dir}, mvq_b.pop_front());
      end
      if (bus_a.res_valid) begin
        if (resq_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_a_unexpected got %0d want none", bus_a.res_moves);
        end else chk("res_a", {bus_a.res_id, bus_a.res_moves, bus_a.res_err}, resq_a.pop_front());
      end
      if (bus_b.res_valid) begin
        if (resq_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_b_unexpected got %0d want none", bus_b.res_moves);
        end else chk("res_b", {bus_b.res_id, bus_b.res_moves, bus_b.res_err}, resq_b.pop_front());
      end
    end
  task automatic wait_grant(input bit id);
    int n = 0;
    while (bus_a.grant == 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.grant == 2'b00) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout got 0 want %0d", id ? 2 : 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "no grant");
    end
    chk("grant", bus_a.grant, id ? 2 : 1);
    chk("ready_owner_only", bus_a.req_ready, id ? 2 : 1);
  endtask
  task automatic load_cells(input bit g, input int gap);
    int idx = 0;
    int n = 0;
    bit v;
    logic [1:0] c;
    c = 2'($urandom_range(3));
    while (idx < CELLS && n < 5000) begin
      v = $urandom_range(99) >= gap;
      bus_a.req_valid[g] = v;
      if (g) bus_a.req_cell[3:2] = c;
      else bus_a.req_cell[1:0] = c;
      if (v && bus_a.req_ready[g]) begin
        cellq.push_back(c);
        idx++;
        c = 2'($urandom_range(3));
      end
      @(negedge clk);
      n++;
    end
    chk("cells_accepted", idx, CELLS);
    bus_a.req_valid[g] = 1'b0;
  endtask
  task automatic run_job(input job_t j);
    int n;
    logic [1:0] d;
    bus_a.req_valid = bus_a.req_valid | j.mask;
    wait_grant(j.id);
    load_cells(j.id, j.gap);
    if (j.spur) begin
      bus_a.slv_out_valid = 1'b1;
      bus_a.slv_out = 2'd3;
      @(negedge clk);
      bus_a.slv_out_valid = 1'b0;
      bus_a.slv_out = 2'd0;
    end
    n = 0;
    while (bus_a.slv_in_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    resq_a.push_back({j.id, 13'(j.a_moves), 2'(j.a_err)});
    resq_b.push_back({j.id, 13'(j.b_moves), 2'(j.b_err)});
    if (j.silent) begin
      n = 1;
      while (!bus_a.res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_cycles_in_range", n >= MAX_WAIT + 1 && n <= MAX_WAIT + 2, 1);
    end else begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < j.moves; i++) begin
        d = 2'($urandom_range(3));
        bus_a.slv_out_valid = 1'b1;
        bus_a.slv_out = d;
        mvq_a.push_back({j.id, d});
        if (i < MB) mvq_b.push_back({j.id, d});
        @(negedge clk);
      end
      bus_a.slv_out_valid = 1'b0;
      bus_a.slv_out = 2'd0;
      n = 0;
      while (!bus_a.res_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("res_after_last_move", n, 1);
    end
    chk("res_lockstep_b", bus_b.res_valid, 1);
    chk("grant_hold", bus_a.grant, j.id ? 2 : 1);
    @(negedge clk);
    chk("grant_clear", bus_a.grant, 0);
    chk("res_valid_pulse", bus_a.res_valid, 0);
    chk("res_moves_hold", bus_a.res_moves, j.a_moves);
  endtask
  initial begin
    int n;
    job_t post;
    jobs[0] = '{2'b11, 0, 40, 1'b0, 1'b0, 1'b0, 40, 0, 20, 2};
    jobs[1] = '{2'b11, 30, 12, 1'b0, 1'b1, 1'b1, 12, 0, 12, 0};
    jobs[2] = '{2'b11, 0, 5, 1'b0, 1'b0, 1'b0, 5, 0, 5, 0};
    jobs[3] = '{2'b10, 0, 0, 1'b1, 1'b0, 1'b1, 0, 1, 0, 1};
    jobs[4] = '{2'b01, 0, 25, 1'b0, 1'b0, 1'b0, 25, 0, 20, 2};
    jobs[5] = '{2'b10, 20, 20, 1'b0, 1'b0, 1'b1, 20, 0, 20, 0};
    jobs[6] = '{2'b01, 0, 1, 1'b0, 1'b0, 1'b0, 1, 0, 1, 0};
    post = '{2'b01, 0, 7, 1'b0, 1'b0, 1'b0, 7, 0, 7, 0};
    bus_a.req_valid = 2'b00;
    bus_a.req_cell = 4'h0;
    bus_a.slv_out_valid = 1'b0;
    bus_a.slv_out = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs_a", outs_a(), 0);
    chk("reset_outs_b", outs_b(), 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs_a", outs_a(), 0);
    foreach (jobs[k]) run_job(jobs[k]);
    bus_a.req_valid = 2'b01;
    wait_grant(1'b0);
    load_cells(1'b0, 0);
    n = 0;
    while (n < 150 && rst_n) begin
      if (bus_a.slv_in_valid) n++;
      if (n < 150) @(negedge clk);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("midfeed_reset_outs_a", outs_a(), 0);
    chk("midfeed_reset_outs_b", outs_b(), 0);
    cellq.delete();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outs_a", outs_a(), 0);
    run_job(post);
    repeat (4) @(negedge clk);
    chk("cellq_empty", cellq.size(), 0);
    chk("mvq_a_empty", mvq_a.size(), 0);
    chk("mvq_b_empty", mvq_b.size(), 0);
    chk("resq_a_empty", resq_a.size(), 0);
    chk("resq_b_empty", resq_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
